// File: rtl/exe_pkg.sv
// Shared types and constants for the exe_unit_w1 command issuer.
package exe_pkg;

  localparam int EXE_M    = 4;
  localparam int EXE_N    = 2;
  localparam int STATUS_W = 4;

  typedef struct packed {
    logic [EXE_N-1:0]        oper;
    logic signed [EXE_M-1:0] a;
    logic signed [EXE_M-1:0] b;
  } exe_cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} issuer_state_t;

endpackage

// File: rtl/exe_cmd_issuer_if.sv
// Command, execution-unit and response signals of exe_cmd_issuer grouped into one bundle.
interface exe_cmd_issuer_if
  import exe_pkg::*;
#(
  parameter int m = 4,
  parameter int n = 2
);

  logic                cmd_valid_unused_guard;
  logic                i_cmd_valid;
  logic                o_cmd_ready;
  logic [n-1:0]        i_cmd_oper;
  logic signed [m-1:0] i_cmd_a;
  logic signed [m-1:0] i_cmd_b;
  logic [n-1:0]        o_exe_oper;
  logic signed [m-1:0] o_exe_a;
  logic signed [m-1:0] o_exe_b;
  logic [m-1:0]        i_exe_result;
  logic [STATUS_W-1:0] i_exe_status;
  logic                o_rsp_valid;
  logic                i_rsp_ready;
  logic [m-1:0]        o_rsp_result;
  logic [STATUS_W-1:0] o_rsp_status;
  logic [7:0]          o_err_cnt;

  modport slave (
    input  i_cmd_valid, i_cmd_oper, i_cmd_a, i_cmd_b,
    input  i_exe_result, i_exe_status, i_rsp_ready,
    output o_cmd_ready, o_exe_oper, o_exe_a, o_exe_b,
    output o_rsp_valid, o_rsp_result, o_rsp_status, o_err_cnt
  );

  modport master (
    output i_cmd_valid, i_cmd_oper, i_cmd_a, i_cmd_b,
    output i_exe_result, i_exe_status, i_rsp_ready,
    input  o_cmd_ready, o_exe_oper, o_exe_a, o_exe_b,
    input  o_rsp_valid, o_rsp_result, o_rsp_status, o_err_cnt
  );

endinterface

// File: rtl/exe_cmd_fifo.sv
// Synchronous command FIFO; pointers wrap mod DEPTH, occupancy counter carries the extra bit.
module exe_cmd_fifo
  import exe_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     i_clk,
  input  logic     i_rsn,
  input  logic     i_push,
  input  exe_cmd_t i_data,
  input  logic     i_pop,
  output exe_cmd_t o_head,
  output logic     o_full,
  output logic     o_empty,
  output logic     o_full_next
);

  localparam int AW = $clog2(DEPTH);

  exe_cmd_t      r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_next;
  logic          w_push;
  logic          w_pop;

  assign o_full      = (r_count == (AW+1)'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign w_push      = i_push && !o_full;
  assign w_pop       = i_pop && !o_empty;
  assign o_head      = r_mem[r_rd_ptr];
  assign o_full_next = (w_count_next == (AW+1)'(DEPTH));

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)
      w_count_next = r_count + 1'b1;
    else if (!w_push && w_pop)
      w_count_next = r_count - 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/exe_cmd_issuer.sv
// Issues buffered commands to exe_unit_w1 one at a time and returns results in order.
// Optional error counter enabled by defining EXE_ERR_COUNT_EN.
module exe_cmd_issuer
  import exe_pkg::*;
#(
  parameter int m     = 4,
  parameter int n     = 2,
  parameter int DEPTH = 4,
  parameter int LAT   = 1
) (
  input logic              i_clk,
  input logic              i_rsn,
  exe_cmd_issuer_if.slave  bus
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  issuer_state_t       r_state;
  exe_cmd_t            r_cur;
  logic [CW-1:0]       r_wait;
  logic                r_ready;
  logic [n-1:0]        r_exe_oper;
  logic signed [m-1:0] r_exe_a;
  logic signed [m-1:0] r_exe_b;
  logic                r_rsp_valid;
  logic [m-1:0]        r_rsp_result;
  logic [STATUS_W-1:0] r_rsp_status;

  exe_cmd_t w_cmd_in;
  exe_cmd_t w_head;
  logic     w_full;
  logic     w_empty;
  logic     w_full_next;
  logic     w_push;
  logic     w_pop;

  assign w_cmd_in = '{oper: bus.i_cmd_oper, a: bus.i_cmd_a, b: bus.i_cmd_b};
  assign w_push   = bus.i_cmd_valid && r_ready && !w_full;
  assign w_pop    = !w_empty && ((r_state == IDLE) || ((r_state == RESP) && bus.i_rsp_ready));

  exe_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk       (i_clk),
    .i_rsn       (i_rsn),
    .i_push      (w_push),
    .i_data      (w_cmd_in),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_full_next (w_full_next)
  );

  // Ready mirrors next-cycle occupancy so upstream sees a purely registered signal.
  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) r_ready <= 1'b0;
    else        r_ready <= !w_full_next;
  end

  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      r_state      <= IDLE;
      r_cur        <= '0;
      r_wait       <= '0;
      r_exe_oper   <= '0;
      r_exe_a      <= '0;
      r_exe_b      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_status <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_cur   <= w_head;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_exe_oper <= r_cur.oper;
          r_exe_a    <= r_cur.a;
          r_exe_b    <= r_cur.b;
          r_wait     <= CW'(LAT - 1);
          r_state    <= WAIT;
        end
        WAIT: begin
          if (r_wait == '0) begin
            r_rsp_result <= bus.i_exe_result;
            r_rsp_status <= bus.i_exe_status;
            r_rsp_valid  <= 1'b1;
            r_state      <= RESP;
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        RESP: begin
          if (bus.i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (w_pop) begin
              r_cur   <= w_head;
              r_state <= ISSUE;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_cmd_ready  = r_ready;
  assign bus.o_exe_oper   = r_exe_oper;
  assign bus.o_exe_a      = r_exe_a;
  assign bus.o_exe_b      = r_exe_b;
  assign bus.o_rsp_valid  = r_rsp_valid;
  assign bus.o_rsp_result = r_rsp_result;
  assign bus.o_rsp_status = r_rsp_status;

`ifdef EXE_ERR_COUNT_EN
  logic [7:0] r_err_cnt;

  // Counts delivered responses flagged by the unit; sticks at the top value.
  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn)
      r_err_cnt <= '0;
    else if ((r_state == RESP) && bus.i_rsp_ready && (r_rsp_status != '0) && (r_err_cnt != 8'hFF))
      r_err_cnt <= r_err_cnt + 1'b1;
  end

  assign bus.o_err_cnt = r_err_cnt;
`else
  assign bus.o_err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_exe_cmd_issuer.sv
// Directed bench for exe_cmd_issuer with a combinational exe_unit_w1 stand-in (LAT=1).
module tb_exe_cmd_issuer;

  logic clk = 1'b0;
  logic rsn;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   lastPushCyc = 0;

  exe_cmd_issuer_if #(.m(4), .n(2)) bus();

  exe_cmd_issuer #(.m(4), .n(2), .DEPTH(4), .LAT(1)) dut (
    .i_clk (clk),
    .i_rsn (rsn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // exe_unit_w1 stand-in: add, sub, and, xor; status = {carry/borrow, overflow, negative, zero}
  logic [3:0] mRes;
  logic       mC;
  logic       mV;
  always_comb begin
    mRes = 4'd0;
    mC   = 1'b0;
    mV   = 1'b0;
    case (bus.o_exe_oper)
      2'b00: begin
        {mC, mRes} = {1'b0, bus.o_exe_a} + {1'b0, bus.o_exe_b};
        mV = (bus.o_exe_a[3] == bus.o_exe_b[3]) && (mRes[3] != bus.o_exe_a[3]);
      end
      2'b01: begin
        {mC, mRes} = {1'b0, bus.o_exe_a} - {1'b0, bus.o_exe_b};
        mV = (bus.o_exe_a[3] != bus.o_exe_b[3]) && (mRes[3] != bus.o_exe_a[3]);
      end
      2'b10:   mRes = bus.o_exe_a & bus.o_exe_b;
      default: mRes = bus.o_exe_a ^ bus.o_exe_b;
    endcase
    bus.i_exe_result = mRes;
    bus.i_exe_status = {mC, mV, mRes[3], (mRes == 4'd0)};
  end

  // Push one command, waiting a bounded time for ready; records the accepting edge.
  task automatic pushCmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    int guard = 0;
    while (bus.o_cmd_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (bus.o_cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL push_timeout ready=%b required 1", bus.o_cmd_ready);
    end
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_oper  = op;
    bus.i_cmd_a     = a;
    bus.i_cmd_b     = b;
    @(posedge clk);
    #1;
    lastPushCyc     = cyc;
    bus.i_cmd_valid = 1'b0;
  endtask

  // Bounded wait for o_rsp_valid, sampled on falling edges.
  task automatic waitRsp(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.o_rsp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic applyReset();
    rsn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rsn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_oper  = '0;
    bus.i_cmd_a     = '0;
    bus.i_cmd_b     = '0;
    bus.i_rsp_ready = 1'b0;
    rsn = 1'b1;
    #1 rsn = 1'b0;
    #2;
    checks++;
    if (bus.o_rsp_valid !== 1'b0 || bus.o_cmd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_valid_ready got %b/%b required 0/0", bus.o_rsp_valid, bus.o_cmd_ready);
    end
    checks++;
    if ({bus.o_exe_oper, bus.o_exe_a, bus.o_exe_b} !== 10'd0) begin
      errors++;
      $display("[TB] FAIL reset_exe got %b required 0", {bus.o_exe_oper, bus.o_exe_a, bus.o_exe_b});
    end
    checks++;
    if ({bus.o_rsp_result, bus.o_rsp_status, bus.o_err_cnt} !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_rsp got %h required 0", {bus.o_rsp_result, bus.o_rsp_status, bus.o_err_cnt});
    end
    @(negedge clk);
    rsn = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.o_cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ready got %b required 1", bus.o_cmd_ready);
    end
  endtask

  task automatic test_single();
    bit got;
    bus.i_rsp_ready = 1'b1;
    pushCmd(2'b00, 4'b0111, 4'b0001);
    @(posedge clk);
    #1;
    checks++;
    if ({bus.o_exe_oper, bus.o_exe_a, bus.o_exe_b} !== 10'd0) begin
      errors++;
      $display("[TB] FAIL single_exe_early got %b required 0", {bus.o_exe_oper, bus.o_exe_a, bus.o_exe_b});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.o_exe_oper, bus.o_exe_a, bus.o_exe_b} !== 10'b00_0111_0001) begin
      errors++;
      $display("[TB] FAIL single_exe_issue got %b required 0001110001", {bus.o_exe_oper, bus.o_exe_a, bus.o_exe_b});
    end
    waitRsp(got);
    checks++;
    if (!got || (cyc - lastPushCyc) != 3) begin
      errors++;
      $display("[TB] FAIL single_latency got valid=%0b after %0d cycles required 3", got, cyc - lastPushCyc);
    end
    checks++;
    if (bus.o_rsp_result !== 4'b1000 || bus.o_rsp_status !== 4'b0110) begin
      errors++;
      $display("[TB] FAIL single_rsp got %b/%b required 1000/0110", bus.o_rsp_result, bus.o_rsp_status);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    bit got;
    logic [3:0] expRes [5] = '{4'b0010, 4'b1110, 4'b1111, 4'b0011, 4'b0000};
    logic [3:0] expSt  [5] = '{4'b0000, 4'b1010, 4'b0010, 4'b0000, 4'b1101};
    bus.i_rsp_ready = 1'b0;
    pushCmd(2'b00, 4'b0001, 4'b0001);
    pushCmd(2'b01, 4'b0011, 4'b0101);
    pushCmd(2'b11, 4'b1010, 4'b0101);
    pushCmd(2'b10, 4'b1111, 4'b0011);
    pushCmd(2'b00, 4'b1000, 4'b1000);
    checks++;
    if (bus.o_cmd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_full_ready got %b required 0", bus.o_cmd_ready);
    end
    // Sixth command offered while full must stall.
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_oper  = 2'b00;
    bus.i_cmd_a     = 4'b0010;
    bus.i_cmd_b     = 4'b0010;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus.o_cmd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_sixth_stall ready got %b required 0", bus.o_cmd_ready);
    end
    bus.i_cmd_valid = 1'b0;
    checks++;
    if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_result !== 4'b0010 || bus.o_rsp_status !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL bp_held_rsp got v=%b %b/%b required 1 0010/0000", bus.o_rsp_valid, bus.o_rsp_result, bus.o_rsp_status);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_result !== 4'b0010 || bus.o_rsp_status !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL bp_stable_rsp got v=%b %b/%b required 1 0010/0000", bus.o_rsp_valid, bus.o_rsp_result, bus.o_rsp_status);
    end
    bus.i_rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      waitRsp(got);
      checks++;
      if (!got || bus.o_rsp_result !== expRes[k] || bus.o_rsp_status !== expSt[k]) begin
        errors++;
        $display("[TB] FAIL bp_rsp%0d got v=%0b %b/%b required %b/%b", k, got, bus.o_rsp_result, bus.o_rsp_status, expRes[k], expSt[k]);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (bus.o_cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_drained_ready got %b required 1", bus.o_cmd_ready);
    end
  endtask

  task automatic test_order();
    bit got;
    int firstPush;
    int prevCyc;
    logic [3:0] expRes [3] = '{4'b0011, 4'b0010, 4'b0000};
    logic [3:0] expSt  [3] = '{4'b0000, 4'b0000, 4'b0001};
    bus.i_rsp_ready = 1'b1;
    pushCmd(2'b00, 4'd1, 4'd2);
    firstPush = lastPushCyc;
    pushCmd(2'b01, 4'd5, 4'd3);
    pushCmd(2'b10, 4'b1100, 4'd2);
    prevCyc = firstPush;
    for (int k = 0; k < 3; k++) begin
      waitRsp(got);
      checks++;
      if (!got || bus.o_rsp_result !== expRes[k] || bus.o_rsp_status !== expSt[k]) begin
        errors++;
        $display("[TB] FAIL order_rsp%0d got v=%0b %b/%b required %b/%b", k, got, bus.o_rsp_result, bus.o_rsp_status, expRes[k], expSt[k]);
      end
      checks++;
      if ((cyc - prevCyc) != 3) begin
        errors++;
        $display("[TB] FAIL order_spacing%0d got %0d cycles required 3", k, cyc - prevCyc);
      end
      prevCyc = cyc;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_midop();
    bit sawValid = 1'b0;
    bus.i_rsp_ready = 1'b1;
    pushCmd(2'b00, 4'd1, 4'd1);
    pushCmd(2'b00, 4'd2, 4'd2);
    @(posedge clk);
    #1;
    rsn = 1'b0;
    #1;
    checks++;
    if (bus.o_rsp_valid !== 1'b0 || bus.o_cmd_ready !== 1'b0 || bus.o_exe_a !== 4'd0) begin
      errors++;
      $display("[TB] FAIL midop_reset got v=%b rdy=%b a=%b required 0/0/0000", bus.o_rsp_valid, bus.o_cmd_ready, bus.o_exe_a);
    end
    @(negedge clk);
    rsn = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.o_cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midop_ready got %b required 1", bus.o_cmd_ready);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.o_rsp_valid !== 1'b0) sawValid = 1'b1;
    end
    checks++;
    if (sawValid) begin
      errors++;
      $display("[TB] FAIL midop_stale got response required none");
    end
  endtask

  task automatic test_err_count();
    bit got;
    logic [7:0] expCnt;
`ifdef EXE_ERR_COUNT_EN
    expCnt = 8'd3;
`else
    expCnt = 8'd0;
`endif
    applyReset();
    checks++;
    if (bus.o_err_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL err_cnt_cleared got %0d required 0", bus.o_err_cnt);
    end
    bus.i_rsp_ready = 1'b1;
    pushCmd(2'b00, 4'b0111, 4'b0001);
    pushCmd(2'b10, 4'b1100, 4'b0010);
    pushCmd(2'b01, 4'b0011, 4'b0101);
    for (int k = 0; k < 3; k++) begin
      waitRsp(got);
      checks++;
      if (!got || bus.o_rsp_status === 4'b0000) begin
        errors++;
        $display("[TB] FAIL err_rsp%0d got v=%0b status=%b required nonzero", k, got, bus.o_rsp_status);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (bus.o_err_cnt !== expCnt) begin
      errors++;
      $display("[TB] FAIL err_cnt got %0d required %0d", bus.o_err_cnt, expCnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_order();
    test_reset_midop();
    test_err_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
